dot_argmax_collect: RTL

- Downstream consumer of the streaming dot-product stage.
- Accepts one signed fixed-point dot-product score per neuron, serially, for NEURON_N neurons per frame.
- Tracks the running maximum and its index, then presents the winning class and its score with a valid/ack handshake.
- Sits between the dot-product engine and the classification output and control logic.

---
 rtl/dot_pkg.sv | 20 ++
 rtl/dot_argmax_collect_argmax_cmp.sv | 31 +++
 rtl/dot_argmax_collect.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product argmax collector: default sizes,
// the Q8.18 fraction-bit count, the collector state encoding and index sizing.
package dot_pkg;

    localparam int DOT_VAL_SIZE  = 26;
    localparam int DOT_NEURON_N  = 10;
    localparam int DOT_FRAC_BITS = 18;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } dot_state_e;

    // Bits needed to index n classes; never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dot_argmax_collect_argmax_cmp.sv
// Combinational running-argmax step: signed strict-greater compare of the
// incoming score against the current maximum, selecting the next max/idx.
module argmax_cmp
    import dot_pkg::*;
#(
    parameter int VAL_SIZE = DOT_VAL_SIZE,
    parameter int IDX_W    = idx_width(DOT_NEURON_N)
) (
    input  logic [VAL_SIZE-1:0] max_in,
    input  logic [IDX_W-1:0]    idx_in,
    input  logic [VAL_SIZE-1:0] value_in,
    input  logic [IDX_W-1:0]    cnt,
    output logic [VAL_SIZE-1:0] max_next,
    output logic [IDX_W-1:0]    idx_next
);

    logic greater_s;

    // Strictly greater so that ties keep the earliest (lowest) index.
    always_comb begin
        greater_s = ($signed(value_in) > $signed(max_in));
        if (greater_s) begin
            max_next = value_in;
            idx_next = cnt;
        end else begin
            max_next = max_in;
            idx_next = idx_in;
        end
    end

endmodule

// File: rtl/dot_argmax_collect.sv
// Collects NEURON_N signed scores per frame and presents the argmax class and
// its score with a valid/ack handshake. Optional score buffer: DOT_ARGMAX_SCORE_BUF_EN.
module dot_argmax_collect
    import dot_pkg::*;
#(
    parameter int VAL_SIZE = DOT_VAL_SIZE,
    parameter int NEURON_N = DOT_NEURON_N,
    parameter int IDX_W    = idx_width(NEURON_N)
) (
    input  logic                clk,
    input  logic                GlobalReset,
    input  logic [VAL_SIZE-1:0] value_in,
    input  logic                value_valid,
    input  logic                result_ack,
    output logic                busy,
    output logic                result_valid,
    output logic [IDX_W-1:0]    class_out,
    output logic [VAL_SIZE-1:0] max_out,
    output logic                drop_err,
    input  logic [IDX_W-1:0]    rd_addr,
    output logic [VAL_SIZE-1:0] rd_data
);

    // One extra bit so the count can reach NEURON_N == 2**IDX_W.
    localparam int              CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NEURON_N - 1);

    dot_state_e          state_r, state_next_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [VAL_SIZE-1:0] max_r;
    logic [IDX_W-1:0]    idx_r;
    logic                busy_r;
    logic                result_valid_r;
    logic                drop_err_r;
    logic                accept_s;
    logic                first_s;
    logic [VAL_SIZE-1:0] cmp_max_s;
    logic [IDX_W-1:0]    cmp_idx_s;

    argmax_cmp #(
        .VAL_SIZE (VAL_SIZE),
        .IDX_W    (IDX_W)
    ) u_cmp (
        .max_in   (max_r),
        .idx_in   (idx_r),
        .value_in (value_in),
        .cnt      (cnt_r[IDX_W-1:0]),
        .max_next (cmp_max_s),
        .idx_next (cmp_idx_s)
    );

    // Next-state and accept decode for the frame FSM.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        first_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (value_valid) begin
                    accept_s     = 1'b1;
                    first_s      = 1'b1;
                    state_next_s = (NEURON_N == 1) ? ST_DONE : ST_COLLECT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (value_valid) begin
                    accept_s = 1'b1;
                    if (cnt_r == LAST_CNT) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_COLLECT;
                    end
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_DONE: begin
                if (result_ack) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state_r        <= ST_IDLE;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            busy_r         <= (state_next_s == ST_COLLECT);
            result_valid_r <= (state_next_s == ST_DONE);
        end
    end

    // Running max/index and arrival counter.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            max_r <= {VAL_SIZE{1'b0}};
            idx_r <= {IDX_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            max_r <= first_s ? value_in : cmp_max_s;
            idx_r <= first_s ? {IDX_W{1'b0}} : cmp_idx_s;
            cnt_r <= cnt_r + CNT_W'(1);
        end else if ((state_r == ST_DONE) && result_ack) begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Sticky flag for scores that arrive while a result is pending.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            drop_err_r <= 1'b0;
        end else if ((state_r == ST_DONE) && value_valid) begin
            drop_err_r <= 1'b1;
        end
    end

    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign class_out    = idx_r;
    assign max_out      = max_r;
    assign drop_err     = drop_err_r;

`ifdef DOT_ARGMAX_SCORE_BUF_EN
    logic [VAL_SIZE-1:0] score_buf_r [NEURON_N];
    logic [VAL_SIZE-1:0] rd_data_s;

    // Capture each accepted score at its arrival slot.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            for (int i = 0; i < NEURON_N; i++) begin
                score_buf_r[i] <= {VAL_SIZE{1'b0}};
            end
        end else begin
            for (int i = 0; i < NEURON_N; i++) begin
                if (accept_s && (cnt_r == CNT_W'(i))) begin
                    score_buf_r[i] <= value_in;
                end
            end
        end
    end

    // Out-of-range addresses read as zero.
    always_comb begin
        rd_data_s = {VAL_SIZE{1'b0}};
        for (int i = 0; i < NEURON_N; i++) begin
            rd_data_s = (rd_addr == IDX_W'(i)) ? score_buf_r[i] : rd_data_s;
        end
    end

    assign rd_data = rd_data_s;
`else
    logic unused_rd_addr_s;

    assign unused_rd_addr_s = ^rd_addr;
    assign rd_data          = {VAL_SIZE{1'b0}};
`endif

endmodule
